// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the two-requester multiply arbiter: state encoding,
// default operand width and the round-robin pick function.
package mul_arbiter_pkg;

  localparam int unsigned c_data_width = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_MULTIPLY = 3'd2,
    ST_DISPLAY  = 3'd3,
    ST_RESPOND  = 3'd4
  } state_t;

  // On a tie, favour whichever requester was not granted last.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] pick;
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester handshake and shared-datapath bus of mul_arbiter.
interface mul_arbiter_if
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned p_data_width = c_data_width
);

  logic                      i_w_req_0;
  logic                      i_w_req_1;
  logic [p_data_width-1:0]   i_w_a_0;
  logic [p_data_width-1:0]   i_w_b_0;
  logic [p_data_width-1:0]   i_w_a_1;
  logic [p_data_width-1:0]   i_w_b_1;
  logic                      o_w_ack_0;
  logic                      o_w_ack_1;
  logic                      o_w_done_0;
  logic                      o_w_done_1;
  logic [2*p_data_width-1:0] o_w_result;
  logic [p_data_width-1:0]   o_w_a;
  logic [p_data_width-1:0]   o_w_b;
  logic                      o_w_write;
  logic                      o_w_multiply;
  logic                      o_w_display;
  logic [2*p_data_width-1:0] i_w_dp_out;

  modport slave (
    input  i_w_req_0, i_w_req_1, i_w_a_0, i_w_b_0, i_w_a_1, i_w_b_1, i_w_dp_out,
    output o_w_ack_0, o_w_ack_1, o_w_done_0, o_w_done_1, o_w_result,
           o_w_a, o_w_b, o_w_write, o_w_multiply, o_w_display
  );

  modport master (
    output i_w_req_0, i_w_req_1, i_w_a_0, i_w_b_0, i_w_a_1, i_w_b_1, i_w_dp_out,
    input  o_w_ack_0, o_w_ack_1, o_w_done_0, o_w_done_1, o_w_result,
           o_w_a, o_w_b, o_w_write, o_w_multiply, o_w_display
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from the request levels, pointer
// moves to the granted requester only when the grant is accepted.
module rr_arbiter2
  import mul_arbiter_pkg::*;
(
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_r;

  // Grant decode from current requests and last-grant pointer.
  always_comb begin
    grant = rr_pick(req, last_r);
  end

  // Last-grant pointer; resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      last_r <= 1'b1;
    end else if (accept) begin
      last_r <= grant[1];
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two requesters onto a shared write/multiply/display datapath and
// returns the product to whichever requester was granted.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned p_data_width = c_data_width
) (
  input  logic         i_w_clk,
  input  logic         i_w_reset,
  mul_arbiter_if.slave bus
);

  localparam int unsigned             c_res_width = 2 * p_data_width;
  localparam logic [p_data_width-1:0] c_op_zero   = {p_data_width{1'b0}};
  localparam logic [c_res_width-1:0]  c_res_zero  = {c_res_width{1'b0}};

  state_t                  state_r;
  state_t                  state_s;
  logic [1:0]              req_s;
  logic [1:0]              grant_s;
  logic [1:0]              ack_s;
  logic                    accept_s;
  logic [1:0]              done_r;
  logic                    owner_r;
  logic                    write_r;
  logic                    multiply_r;
  logic                    display_r;
  logic [p_data_width-1:0] a_r;
  logic [p_data_width-1:0] b_r;
  logic [c_res_width-1:0]  result_r;

  assign req_s    = {bus.i_w_req_1, bus.i_w_req_0};
  assign accept_s = |ack_s;

  rr_arbiter2 u_rr_arbiter2 (
    .i_w_clk   (i_w_clk),
    .i_w_reset (i_w_reset),
    .req       (req_s),
    .accept    (accept_s),
    .grant     (grant_s)
  );

  // Acceptance must land in the same IDLE cycle the request is seen, so it is
  // decoded from the state register rather than registered again.
  always_comb begin
    ack_s = 2'b00;
    if (!i_w_reset && (state_r == ST_IDLE)) begin
      ack_s = grant_s;
    end else begin
      ack_s = 2'b00;
    end
  end

  // Next-state decode; everything past IDLE walks the fixed pipeline.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE:    state_s = ST_MULTIPLY;
      ST_MULTIPLY: state_s = ST_DISPLAY;
      ST_DISPLAY:  state_s = ST_RESPOND;
      ST_RESPOND:  state_s = ST_IDLE;
      default:     state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Strobes and done are registered from the next state so each one is high
  // for exactly the cycle spent in its state.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      write_r    <= 1'b0;
      multiply_r <= 1'b0;
      display_r  <= 1'b0;
      done_r     <= 2'b00;
    end else begin
      write_r    <= (state_s == ST_WRITE);
      multiply_r <= (state_s == ST_MULTIPLY);
      display_r  <= (state_s == ST_DISPLAY);
      done_r     <= (state_s == ST_RESPOND) ? (owner_r ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // Operand latch doubles as the datapath drive; cleared when DISPLAY ends,
  // which is also when the product is captured.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      owner_r  <= 1'b0;
      a_r      <= c_op_zero;
      b_r      <= c_op_zero;
      result_r <= c_res_zero;
    end else if (accept_s) begin
      owner_r  <= ack_s[1];
      a_r      <= ack_s[1] ? bus.i_w_a_1 : bus.i_w_a_0;
      b_r      <= ack_s[1] ? bus.i_w_b_1 : bus.i_w_b_0;
      result_r <= result_r;
    end else if (state_r == ST_DISPLAY) begin
      owner_r  <= owner_r;
      a_r      <= c_op_zero;
      b_r      <= c_op_zero;
      result_r <= bus.i_w_dp_out;
    end else begin
      owner_r  <= owner_r;
      a_r      <= a_r;
      b_r      <= b_r;
      result_r <= result_r;
    end
  end

  assign bus.o_w_ack_0    = ack_s[0];
  assign bus.o_w_ack_1    = ack_s[1];
  assign bus.o_w_done_0   = done_r[0];
  assign bus.o_w_done_1   = done_r[1];
  assign bus.o_w_result   = result_r;
  assign bus.o_w_a        = a_r;
  assign bus.o_w_b        = b_r;
  assign bus.o_w_write    = write_r;
  assign bus.o_w_multiply = multiply_r;
  assign bus.o_w_display  = display_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbiter.
module tb_mul_arbiter;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mul_arbiter_if #(.p_data_width(8)) bus ();

  mul_arbiter #(.p_data_width(8)) dut (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: operands registered on write, product on multiply, shown on display.
  logic [7:0]  dp_a_r;
  logic [7:0]  dp_b_r;
  logic [15:0] dp_p_r;
  always_ff @(posedge clk) begin
    if (bus.o_w_write) begin
      dp_a_r <= bus.o_w_a;
      dp_b_r <= bus.o_w_b;
    end
    if (bus.o_w_multiply) begin
      dp_p_r <= 16'(dp_a_r) * 16'(dp_b_r);
    end
  end
  assign bus.i_w_dp_out = bus.o_w_display ? dp_p_r : 16'd0;

  task automatic check_value(input string tag, input longint unsigned got,
                             input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Transaction model: an op accepted at cycle T shows write/multiply/display
  // at T+1..T+3, done at T+4, and the arbiter is free again from T+5.
  int              cyc = 0;
  int              m_ack_cyc = -100;
  int              m_last = 1;
  int              m_owner = 0;
  longint unsigned m_a = 0;
  longint unsigned m_b = 0;
  longint unsigned m_result = 0;
  logic [1:0]      m_grant = 2'b00;
  int              obs_ack_cyc[$];
  int              obs_grant[$];

  task automatic cycle_end();
    int         off;
    logic [1:0] r;
    logic [1:0] eg;
    @(negedge clk);
    r  = {bus.i_w_req_1, bus.i_w_req_0};
    eg = 2'b00;
    if (rst) begin
      m_ack_cyc = -100;
      m_last    = 1;
      m_result  = 0;
    end
    off = cyc - m_ack_cyc;
    if (!rst && off >= 5 && r != 2'b00) begin
      if (r == 2'b11) eg = (m_last == 1) ? 2'b01 : 2'b10;
      else            eg = r;
    end
    if (off == 4) m_result = m_a * m_b;
    check_value("ack_0", bus.o_w_ack_0, eg[0]);
    check_value("ack_1", bus.o_w_ack_1, eg[1]);
    check_value("write", bus.o_w_write, off == 1);
    check_value("multiply", bus.o_w_multiply, off == 2);
    check_value("display", bus.o_w_display, off == 3);
    check_value("done_0", bus.o_w_done_0, off == 4 && m_owner == 0);
    check_value("done_1", bus.o_w_done_1, off == 4 && m_owner == 1);
    check_value("op_a", bus.o_w_a, (off >= 1 && off <= 3) ? m_a : 0);
    check_value("op_b", bus.o_w_b, (off >= 1 && off <= 3) ? m_b : 0);
    check_value("result", bus.o_w_result, m_result);
    if (bus.o_w_ack_0 || bus.o_w_ack_1) begin
      obs_ack_cyc.push_back(cyc);
      obs_grant.push_back(bus.o_w_ack_1 ? 1 : 0);
    end
    if (eg != 2'b00) begin
      m_ack_cyc = cyc;
      m_owner   = eg[1] ? 1 : 0;
      m_last    = m_owner;
      m_a       = eg[1] ? bus.i_w_a_1 : bus.i_w_a_0;
      m_b       = eg[1] ? bus.i_w_b_1 : bus.i_w_b_0;
    end
    m_grant = eg;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Run n cycles; unless keep is set, a requester drops its request once accepted.
  task automatic run(input int n, input bit keep);
    for (int i = 0; i < n; i++) begin
      cycle_end();
      if (!keep) begin
        if (m_grant[0]) bus.i_w_req_0 = 1'b0;
        if (m_grant[1]) bus.i_w_req_1 = 1'b0;
      end
    end
  endtask

  task automatic clear_obs();
    obs_ack_cyc.delete();
    obs_grant.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_w_req_0 = 1'b0; bus.i_w_req_1 = 1'b0;
    bus.i_w_a_0 = 8'd0; bus.i_w_b_0 = 8'd0;
    bus.i_w_a_1 = 8'd0; bus.i_w_b_1 = 8'd0;
    #1;
    run(2, 1'b0);
    rst = 1'b0;
    run(1, 1'b0);

    // Single request 2*4.
    clear_obs();
    bus.i_w_a_0 = 8'd2; bus.i_w_b_0 = 8'd4; bus.i_w_req_0 = 1'b1;
    run(6, 1'b0);
    check_value("single_ack_count", obs_grant.size(), 1);
    if (obs_grant.size() >= 1) check_value("single_owner", obs_grant[0], 0);
    check_value("single_result", bus.o_w_result, 8);

    // Tie after reset: requester 0 first, then requester 1, 5 cycles apart.
    rst = 1'b1;
    run(1, 1'b0);
    rst = 1'b0;
    clear_obs();
    bus.i_w_a_0 = 8'd3; bus.i_w_b_0 = 8'd5; bus.i_w_req_0 = 1'b1;
    bus.i_w_a_1 = 8'd6; bus.i_w_b_1 = 8'd7; bus.i_w_req_1 = 1'b1;
    run(5, 1'b0);
    check_value("tie_result_first", bus.o_w_result, 15);
    run(7, 1'b0);
    check_value("tie_result_second", bus.o_w_result, 42);
    check_value("tie_ack_count", obs_grant.size(), 2);
    if (obs_grant.size() >= 2) begin
      check_value("tie_first_owner", obs_grant[0], 0);
      check_value("tie_second_owner", obs_grant[1], 1);
      check_value("tie_spacing", obs_ack_cyc[1] - obs_ack_cyc[0], 5);
    end

    // Sustained tie over four operations.
    clear_obs();
    bus.i_w_a_0 = 8'd10; bus.i_w_b_0 = 8'd11; bus.i_w_req_0 = 1'b1;
    bus.i_w_a_1 = 8'd12; bus.i_w_b_1 = 8'd13; bus.i_w_req_1 = 1'b1;
    run(20, 1'b1);
    bus.i_w_req_0 = 1'b0; bus.i_w_req_1 = 1'b0;
    run(2, 1'b0);
    check_value("sustain_ack_count", obs_grant.size(), 4);
    for (int i = 0; i < obs_grant.size() && i < 4; i++) begin
      check_value("sustain_owner", obs_grant[i], i % 2);
    end

    // Full-scale operands, changed to zero right after acceptance.
    bus.i_w_a_1 = 8'd255; bus.i_w_b_1 = 8'd255; bus.i_w_req_1 = 1'b1;
    run(1, 1'b0);
    bus.i_w_a_1 = 8'd0; bus.i_w_b_1 = 8'd0;
    run(5, 1'b0);
    check_value("max_result", bus.o_w_result, 65025);

    // Reset asserted mid-MULTIPLY aborts the operation.
    bus.i_w_a_0 = 8'd9; bus.i_w_b_0 = 8'd11; bus.i_w_req_0 = 1'b1;
    run(2, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_value("rst_write", bus.o_w_write, 0);
    check_value("rst_multiply", bus.o_w_multiply, 0);
    check_value("rst_display", bus.o_w_display, 0);
    check_value("rst_done", {bus.o_w_done_1, bus.o_w_done_0}, 0);
    check_value("rst_ack", {bus.o_w_ack_1, bus.o_w_ack_0}, 0);
    check_value("rst_ops", {bus.o_w_a, bus.o_w_b}, 0);
    check_value("rst_result", bus.o_w_result, 0);
    run(2, 1'b0);
    rst = 1'b0;
    bus.i_w_a_1 = 8'd13; bus.i_w_b_1 = 8'd17; bus.i_w_req_1 = 1'b1;
    run(7, 1'b0);
    check_value("post_rst_result", bus.o_w_result, 221);

    // Random traffic: requests rise, are occasionally withdrawn before
    // acceptance, and operands are scrambled once accepted.
    for (int i = 0; i < 800; i++) begin
      cycle_end();
      if (m_grant[0]) begin
        bus.i_w_req_0 = ($urandom_range(0, 3) == 0);
        bus.i_w_a_0 = 8'($urandom_range(0, 255));
        bus.i_w_b_0 = 8'($urandom_range(0, 255));
      end else if (!bus.i_w_req_0 && $urandom_range(0, 2) == 0) begin
        bus.i_w_req_0 = 1'b1;
        bus.i_w_a_0 = 8'($urandom_range(0, 255));
        bus.i_w_b_0 = 8'($urandom_range(0, 255));
      end else if (bus.i_w_req_0 && $urandom_range(0, 19) == 0) begin
        bus.i_w_req_0 = 1'b0;
      end
      if (m_grant[1]) begin
        bus.i_w_req_1 = ($urandom_range(0, 3) == 0);
        bus.i_w_a_1 = 8'($urandom_range(0, 255));
        bus.i_w_b_1 = 8'($urandom_range(0, 255));
      end else if (!bus.i_w_req_1 && $urandom_range(0, 2) == 0) begin
        bus.i_w_req_1 = 1'b1;
        bus.i_w_a_1 = 8'($urandom_range(0, 255));
        bus.i_w_b_1 = 8'($urandom_range(0, 255));
      end else if (bus.i_w_req_1 && $urandom_range(0, 19) == 0) begin
        bus.i_w_req_1 = 1'b0;
      end
    end
    bus.i_w_req_0 = 1'b0; bus.i_w_req_1 = 1'b0;
    run(6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter: p_data_width, 8, operand width in bits; result width is 2*p_data_width.
REQ-002 SHALL have port: i_w_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: i_w_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: i_w_req_0 / i_w_req_1  input  1 each  requester operation requests, level, held until acknowledged.
REQ-005 SHALL have ports: i_w_a_0, i_w_b_0, i_w_a_1, i_w_b_1  input  p_data_width each  requester operands.
REQ-006 SHALL have ports: o_w_ack_0 / o_w_ack_1  output  1 each  one-cycle acceptance pulse.
REQ-007 SHALL have ports: o_w_done_0 / o_w_done_1  output  1 each  one-cycle completion pulse.
REQ-008 SHALL have port: o_w_result  output  2*p_data_width  last completed product, held between completions.
REQ-009 SHALL have ports: o_w_a, o_w_b  output  p_data_width each  operands driven to the shared multiply-register datapath.
REQ-010 SHALL have ports: o_w_write, o_w_multiply, o_w_display  output  1 each  datapath control strobes.
REQ-011 SHALL have port: i_w_dp_out  input  2*p_data_width  datapath output, valid while o_w_display is high.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, MULTIPLY, DISPLAY, RESPOND; transitions are unconditional WRITE->MULTIPLY->DISPLAY->RESPOND->IDLE.
REQ-013 In IDLE with any request high, SHALL grant one requester, pulse its o_w_ack_x that cycle, latch its a/b, record the grantee, and go to WRITE.
REQ-014 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; a single request is granted immediately.
REQ-015 After reset the last-grant pointer SHALL equal requester 1, so requester 0 wins the first tie.
REQ-016 o_w_a/o_w_b SHALL drive the latched operands from WRITE through DISPLAY, and 0 otherwise.
REQ-017 o_w_write SHALL be high only in WRITE, o_w_multiply only in MULTIPLY, o_w_display only in DISPLAY; all strobes are registered, one cycle each, mutually exclusive.
REQ-018 In DISPLAY, SHALL capture i_w_dp_out into o_w_result on the clock edge that leaves DISPLAY.
REQ-019 In RESPOND, SHALL pulse o_w_done_x of the recorded grantee only.
REQ-020 Latency SHALL be fixed: done asserts exactly 4 cycles after the ack cycle.
REQ-021 Throughput: the next ack SHALL occur no earlier than the cycle after RESPOND (5-cycle minimum spacing).
REQ-022 Requests arriving outside IDLE SHALL be ignored until IDLE; a request deasserted before ack SHALL be lost, with no ack.
REQ-023 Operand changes on i_w_a_x/i_w_b_x after ack SHALL NOT affect the in-flight operation.

Reset
REQ-024 While i_w_reset is high, SHALL force state IDLE, all acks/dones/strobes 0, o_w_a=o_w_b=0, o_w_result=0, and the pointer to requester 1, independent of the clock.
REQ-025 Reset mid-operation SHALL abort the operation with no done pulse; the first request after release follows REQ-013.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding and the default data-width constant.
REQ-027 Arbitration SHALL be a sub-module rr_arbiter2 (request in, one-hot grant out, pointer update on accept); the FSM and strobe logic stay in mul_arbiter.

Verification
REQ-028 The bench SHALL model the datapath as: operands registered on write, product registered on multiply, driven on i_w_dp_out while display is high.
REQ-029 Single request: req_0, a=2, b=4 -> ack_0 at cycle T, write/multiply/display at T+1..T+3, done_0 at T+4, o_w_result=8.
REQ-030 Tie after reset: req_0 (3,5) and req_1 (6,7) together -> requester 0 first, result 15; then requester 1, result 42; ack spacing 5 cycles.
REQ-031 Sustained tie: both held for 4 operations -> grants alternate 0,1,0,1; each done pulses only its owner.
REQ-032 Boundary width: a=255, b=255 -> o_w_result=65025; operands changed to 0 after ack -> result still 65025.
REQ-033 Reset in MULTIPLY: assert i_w_reset mid-cycle -> all outputs 0 immediately, no done; a request after release completes normally with the correct product.
